uart_rx_loader: RTL and testbench

- Frame-parsing controller that drains the uart_rx byte FIFO and loads 32-bit words into a program/data memory (FileIO path).
- Protocol: sync byte, 16-bit word count, little-endian payload words, XOR checksum byte.
- Sits between uart_rx (read_en/rx_data/rx_data_rdy) and the memory write port; reports done, checksum error and overrun status.

---
 rtl/uart_loader_pkg.sv | 11 +
 rtl/uart_loader_word_asm.sv | 34 +++
 rtl/uart_rx_loader.sv | 143 ++++++++++++++
 tb/tb_uart_rx_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART frame loader.
package uart_loader_pkg;
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, PAYLOAD, CHECK} state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;
endpackage

// File: rtl/uart_loader_word_asm.sv
// Little-endian payload word assembler with byte-lane counter and running XOR checksum.
module uart_loader_word_asm
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word,
    output logic [7:0]  o_chk_byte
);
    logic [1:0]  r_lane;
    logic [23:0] r_word;
    logic [7:0]  r_xor;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_lane <= LANE0;
            r_word <= '0;
            r_xor  <= '0;
        end else if (i_byte_vld) begin
            r_lane <= r_lane + 2'd1;
            r_word <= {i_byte, r_word[23:8]};
            r_xor  <= r_xor ^ i_byte;
        end
    end

    // After three shifts r_word holds bytes 0..2; the 4th byte completes the word combinationally.
    assign o_word_valid = i_byte_vld && (r_lane == LANE3);
    assign o_word       = {i_byte, r_word};
    assign o_chk_byte   = r_xor;
endmodule

// File: rtl/uart_rx_loader.sv
// UART frame loader: sync, 16-bit word count, LE payload words, XOR checksum -> memory writes.
// Optional inter-byte timeout when UART_RX_LOADER_TIMEOUT_EN is defined.
module uart_rx_loader
    import uart_loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
`ifdef UART_RX_LOADER_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 2_000_000
`endif
) (
    input  logic              clk_rx,
    input  logic              rst_clk_rx,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_rdy,
    input  logic              lost_data,
    output logic              read_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
`ifdef UART_RX_LOADER_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic              chk_err,
    output logic              ovr_err
);
    state_t r_state, w_state_nxt;

    logic              r_pop_blk, r_lost_q;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr, r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_mem_we, r_done, r_chk_err, r_ovr_err;

    logic        w_busy, w_lost_rise, w_to, w_abort, w_accept, w_sync, w_pay_byte;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic [7:0]  w_chk_byte;

    assign w_busy      = (r_state != IDLE);
    assign w_lost_rise = lost_data && !r_lost_q;
    assign w_abort     = w_busy && (w_lost_rise || w_to);
    // pop_blk leaves one cycle for the FIFO head to update after each pop
    assign w_accept    = rx_data_rdy && !r_pop_blk && !w_abort && !rst_clk_rx;
    assign w_sync      = w_accept && (r_state == IDLE) && (rx_data == SYNC_BYTE);
    assign w_pay_byte  = w_accept && (r_state == PAYLOAD);

    uart_loader_word_asm u_asm (
        .clk          (clk_rx),
        .rst          (rst_clk_rx),
        .i_clr        (w_sync || w_abort),
        .i_byte_vld   (w_pay_byte),
        .i_byte       (rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_chk_byte   (w_chk_byte)
    );

    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = IDLE;
        end else if (w_accept) begin
            case (r_state)
                IDLE:    if (rx_data == SYNC_BYTE) w_state_nxt = LEN0;
                LEN0:    w_state_nxt = LEN1;
                LEN1:    w_state_nxt = ({rx_data, r_cnt[7:0]} == 16'd0) ? CHECK : PAYLOAD;
                PAYLOAD: if (w_word_valid && r_cnt == 16'd1) w_state_nxt = CHECK;
                CHECK:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            r_pop_blk   <= 1'b0;
            r_lost_q    <= 1'b0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_done      <= 1'b0;
            r_chk_err   <= 1'b0;
            r_ovr_err   <= 1'b0;
        end else begin
            r_pop_blk <= w_accept;
            r_lost_q  <= lost_data;
            r_mem_we  <= w_word_valid;
            r_done    <= w_accept && (r_state == CHECK) && (rx_data == w_chk_byte);
            if (w_busy && w_lost_rise) r_ovr_err <= 1'b1;
            if (w_sync) begin
                r_chk_err <= 1'b0;
                r_addr    <= '0;
            end
            if (w_accept && (r_state == CHECK) && (rx_data != w_chk_byte)) r_chk_err <= 1'b1;
            if (w_accept && (r_state == LEN0)) r_cnt[7:0]  <= rx_data;
            if (w_accept && (r_state == LEN1)) r_cnt[15:8] <= rx_data;
            if (w_word_valid) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_word;
                r_addr      <= r_addr + 1'b1;
                r_cnt       <= r_cnt - 16'd1;
            end
        end
    end

`ifdef UART_RX_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx || !w_busy || w_accept) r_to_cnt <= '0;
        else                                   r_to_cnt <= r_to_cnt + 1'b1;
        if (rst_clk_rx) r_timeout <= 1'b0;
        else            r_timeout <= w_to;
    end

    assign w_to    = w_busy && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign timeout = r_timeout;
`else
    assign w_to = 1'b0;
`endif

    assign read_en   = w_accept;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = w_busy;
    assign done      = r_done;
    assign chk_err   = r_chk_err;
    assign ovr_err   = r_ovr_err;
endmodule

// File: tb/tb_uart_rx_loader.sv
// Scoreboard bench for uart_rx_loader: FWFT FIFO model feeding frames, expected writes queued.
module tb_uart_rx_loader;
    localparam int AW = 2;

    logic          clk_rx = 1'b0;
    logic          rst_clk_rx = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_data_rdy = 1'b0;
    logic          lost_data = 1'b0;
    logic          read_en, mem_we, busy, done, chk_err, ovr_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
`ifdef UART_RX_LOADER_TIMEOUT_EN
    logic          timeout;
`endif

    uart_rx_loader #(.ADDR_W(AW)) dut (
        .clk_rx      (clk_rx),
        .rst_clk_rx  (rst_clk_rx),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .lost_data   (lost_data),
        .read_en     (read_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
`ifdef UART_RX_LOADER_TIMEOUT_EN
        .timeout     (timeout),
`endif
        .chk_err     (chk_err),
        .ovr_err     (ovr_err)
    );

    always #5 clk_rx = ~clk_rx;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          b2b_viol = 0;
    logic [7:0]  q[$];
    wr_t         exp_q[$];
    logic [31:0] wds[0:7];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FWFT FIFO model: pop on read_en seen at the edge, present new head just after
    logic pop_now, prev_pop = 1'b0;
    always @(posedge clk_rx) begin
        pop_now = read_en;
        if (pop_now && prev_pop) b2b_viol++;
        prev_pop = pop_now;
        #1;
        if (pop_now && q.size() > 0) void'(q.pop_front());
        rx_data_rdy = (q.size() > 0);
        rx_data     = (q.size() > 0) ? q[0] : 8'h00;
    end

    always @(negedge clk_rx) begin
        if (done) done_cnt++;
        if (mem_we) begin
            if (exp_q.size() == 0) chk("unexp_we", 64'(mem_we), 64'd0);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                chk("wr_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    task automatic frame(input int n, input bit bad, input int nb);
        logic [7:0]    x, b;
        logic [AW-1:0] a;
        wr_t           e;
        x = 8'h00;
        a = '0;
        q.push_back(8'hA5);
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        for (int i = 0; i < nb; i++) begin
            b = wds[i/4][8*(i%4) +: 8];
            x ^= b;
            q.push_back(b);
            if (i % 4 == 3) begin
                e.addr = a;
                e.data = wds[i/4];
                exp_q.push_back(e);
                a = a + 1'b1;
            end
        end
        if (nb == 4*n) q.push_back(bad ? (x ^ 8'hFF) : x);
    endtask

    task automatic wait_drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_rx);
            if (q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'd1);
        repeat (3) @(negedge clk_rx);
    endtask

    task automatic wait_empty(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_rx);
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 64'(ok), 64'd1);
        repeat (4) @(negedge clk_rx);
    endtask

    int d0;
    initial begin
        repeat (3) @(negedge clk_rx);
        chk("rst_mem_we",  64'(mem_we),    64'd0);
        chk("rst_read_en", 64'(read_en),   64'd0);
        chk("rst_busy",    64'(busy),      64'd0);
        chk("rst_done",    64'(done),      64'd0);
        chk("rst_chk_err", 64'(chk_err),   64'd0);
        chk("rst_ovr_err", 64'(ovr_err),   64'd0);
        chk("rst_addr",    64'(mem_addr),  64'd0);
        chk("rst_wdata",   64'(mem_wdata), 64'd0);
        rst_clk_rx = 1'b0;

        // good two-word frame
        wds[0] = 32'h44332211; wds[1] = 32'h88776655;
        d0 = done_cnt;
        frame(2, 1'b0, 8);
        wait_drain("a_drain");
        chk("a_done",    64'(done_cnt - d0), 64'd1);
        chk("a_chk_err", 64'(chk_err),       64'd0);
        chk("a_writes",  64'(exp_q.size()),  64'd0);

        // bad checksum: writes still land, no done
        d0 = done_cnt;
        frame(2, 1'b1, 8);
        wait_drain("b_drain");
        chk("b_done",    64'(done_cnt - d0), 64'd0);
        chk("b_chk_err", 64'(chk_err),       64'd1);
        chk("b_writes",  64'(exp_q.size()),  64'd0);

        // next good frame clears chk_err
        d0 = done_cnt;
        frame(2, 1'b0, 8);
        wait_drain("c_drain");
        chk("c_done",    64'(done_cnt - d0), 64'd1);
        chk("c_chk_err", 64'(chk_err),       64'd0);

        // garbage then empty frame
        d0 = done_cnt;
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h5A);
        frame(0, 1'b0, 0);
        wait_drain("d_drain");
        chk("d_done", 64'(done_cnt - d0), 64'd1);

        // five words with 2-bit address: 0,1,2,3,0
        for (int i = 0; i < 5; i++) wds[i] = $urandom;
        d0 = done_cnt;
        frame(5, 1'b0, 20);
        wait_drain("e_drain");
        chk("e_done",   64'(done_cnt - d0), 64'd1);
        chk("e_writes", 64'(exp_q.size()),  64'd0);

        // overrun after 6 payload bytes
        frame(3, 1'b0, 6);
        wait_empty("f_empty");
        chk("f_busy_pre", 64'(busy), 64'd1);
        lost_data = 1'b1;
        @(negedge clk_rx);
        chk("f_ovr_err", 64'(ovr_err), 64'd1);
        chk("f_busy",    64'(busy),    64'd0);
        repeat (4) @(negedge clk_rx);
        chk("f_writes",  64'(exp_q.size()), 64'd0);
        chk("f_ovr_sticky", 64'(ovr_err), 64'd1);
        lost_data = 1'b0;

        // reset mid-payload
        frame(2, 1'b0, 3);
        wait_empty("g_empty");
        rst_clk_rx = 1'b1;
        @(negedge clk_rx);
        chk("g_busy",    64'(busy),    64'd0);
        chk("g_mem_we",  64'(mem_we),  64'd0);
        chk("g_done",    64'(done),    64'd0);
        chk("g_chk_err", 64'(chk_err), 64'd0);
        chk("g_ovr_err", 64'(ovr_err), 64'd0);
        chk("g_addr",    64'(mem_addr), 64'd0);
        rst_clk_rx = 1'b0;
        wds[0] = 32'hDEADBEEF;
        d0 = done_cnt;
        frame(1, 1'b0, 4);
        wait_drain("h_drain");
        chk("h_done",   64'(done_cnt - d0), 64'd1);
        chk("h_writes", 64'(exp_q.size()),  64'd0);

        chk("b2b_pops", 64'(b2b_viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
